// File: rtl/dk_sound_sequencer_pkg.sv
// Shared types and constants for the discrete sound sequencer.
package dk_sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ON   = 2'd2
  } voice_state_t;

  localparam int VOICE_WALK  = 0;
  localparam int VOICE_JUMP  = 1;
  localparam int VOICE_STOMP = 2;
  localparam int HOLD_CNT_W  = 16;

endpackage

// File: rtl/dk_sound_sequencer_if.sv
// Sound-latch request bus and sequencer status outputs.
interface dk_sound_sequencer_if #(
  parameter int NUM_VOICES = 3
) ();

  logic                  cpu_wr;
  logic [7:0]            cpu_data;
  logic                  sample_en;
  logic                  slow_en;
  logic [NUM_VOICES-1:0] voice_en;
  logic                  mute;
  logic                  busy;

  modport master (
    output cpu_wr, cpu_data,
    input  sample_en, slow_en, voice_en, mute, busy
  );

  modport slave (
    input  cpu_wr, cpu_data,
    output sample_en, slow_en, voice_en, mute, busy
  );

endinterface

// File: rtl/dk_sound_voice_timer.sv
// One voice enable FSM: stretches short requests to a minimum on-time, advancing on sample ticks.
module dk_sound_voice_timer
  import dk_sound_pkg::*;
#(
  parameter int MIN_HOLD_SAMPLES = 2400
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic mute_i,
  input  logic req_i,
  output logic en_o
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(MIN_HOLD_SAMPLES - 1);

  voice_state_t            state_q, state_d;
  logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    prev_q, prev_d;
  logic                    rise;

  assign rise = req_i && !prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  // While muted, prev stays 0 so a request held through warm-up fires as a fresh edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    if (tick_i) begin
      if (mute_i) begin
        state_d = IDLE;
        cnt_d   = '0;
        prev_d  = 1'b0;
      end else begin
        prev_d = req_i;
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
          HOLD: begin
            if (rise) begin
              cnt_d = HOLD_LOAD;
            end else if (cnt_q == '0) begin
              state_d = req_i ? ON : IDLE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          ON: begin
            if (!req_i) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    en_o = (state_q != IDLE);
  end

endmodule

// File: rtl/dk_sound_sequencer.sv
// Sample-rate enable generation, warm-up mute, sound-latch capture and per-voice timers.
module dk_sound_sequencer
  import dk_sound_pkg::*;
#(
  parameter int CLOCK_RATE       = 1000000,
  parameter int SAMPLE_RATE      = 48000,
  parameter int NUM_VOICES       = 3,
  parameter int MIN_HOLD_SAMPLES = 2400,
  parameter int WARMUP_SAMPLES   = 4800,
  parameter int DIV_SHIFT        = 3
) (
  input  logic               clk,
  input  logic               reset,
  dk_sound_sequencer_if.slave bus
);

  localparam int DW = (DIV_SHIFT > 0) ? DIV_SHIFT : 1;

  logic [31:0]           acc_q, acc_d, acc_sum;
  logic                  sample_en_q, sample_en_d;
  logic [DW-1:0]         div_q;
  logic [NUM_VOICES-1:0] cmd_q;
  logic [15:0]           warm_q;
  logic                  mute_q;
  logic [NUM_VOICES-1:0] voice_en;

  // Fractional rate accumulator: exactly SAMPLE_RATE pulses per CLOCK_RATE clocks.
  always_comb begin
    acc_sum     = acc_q + 32'(SAMPLE_RATE);
    acc_d       = acc_sum;
    sample_en_d = 1'b0;
    if (acc_sum >= 32'(CLOCK_RATE)) begin
      acc_d       = acc_sum - 32'(CLOCK_RATE);
      sample_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      sample_en_q <= 1'b0;
      div_q       <= '0;
      cmd_q       <= '0;
      warm_q      <= 16'(WARMUP_SAMPLES);
      mute_q      <= (WARMUP_SAMPLES != 0);
    end else begin
      acc_q       <= acc_d;
      sample_en_q <= sample_en_d;
      if (sample_en_q) div_q <= div_q + DW'(1);
      if (bus.cpu_wr) cmd_q <= bus.cpu_data[NUM_VOICES-1:0];
      if (sample_en_q && mute_q) begin
        warm_q <= warm_q - 16'd1;
        if (warm_q == 16'd1) mute_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    dk_sound_voice_timer #(
      .MIN_HOLD_SAMPLES(MIN_HOLD_SAMPLES)
    ) u_voice (
      .clk   (clk),
      .reset (reset),
      .tick_i(sample_en_q),
      .mute_i(mute_q),
      .req_i (cmd_q[i]),
      .en_o  (voice_en[i])
    );
  end

  assign bus.sample_en = sample_en_q;
  assign bus.slow_en   = sample_en_q && ((DIV_SHIFT == 0) || (div_q == '0));
  assign bus.voice_en  = voice_en;
  assign bus.mute      = mute_q;
  assign bus.busy      = |voice_en;

endmodule
